fpu_issue_queue: RTL and testbench

- Upstream command buffer and sequencer for the FPU block: accepts operand/operation commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the FPU by driving its operand and operation inputs and pulsing its start/Reset input. Waits for a rising edge on the FPU's Done, then presents the result over a valid/ready response interface.
- Sits between the command source (core or bench driver) and the FPU; a timeout guards against a hung FPU.

---
 rtl/fpu_issue_queue_if.sv | 45 ++++
 rtl/fpu_issue_queue.sv | 196 +++++++++++++++++++
 tb/tb_fpu_issue_queue.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_queue_if.sv
// Bundles the command, FPU-side and response signals of the FPU issue queue.
// The master is the environment (command source, FPU, response sink); the slave is the queue.
interface fpu_issue_queue_if #(
    parameter int PRECISION = 32
);
    logic                 CmdValid;
    logic                 CmdReady;
    logic [PRECISION-1:0] CmdA;
    logic [PRECISION-1:0] CmdB;
    logic [1:0]           CmdOp;

    logic [PRECISION-1:0] FpuA;
    logic [PRECISION-1:0] FpuB;
    logic [1:0]           FpuOp;
    logic                 FpuStart;
    logic [PRECISION-1:0] FpuResult;
    logic                 FpuDone;

    logic                 RspValid;
    logic                 RspReady;
    logic [PRECISION-1:0] RspResult;
    logic [1:0]           RspOp;
    logic                 RspTimeout;
    logic                 Busy;

    modport master (
        output CmdValid, CmdA, CmdB, CmdOp,
        input  CmdReady,
        input  FpuA, FpuB, FpuOp, FpuStart,
        output FpuResult, FpuDone,
        input  RspValid, RspResult, RspOp, RspTimeout,
        output RspReady,
        input  Busy
    );

    modport slave (
        input  CmdValid, CmdA, CmdB, CmdOp,
        output CmdReady,
        output FpuA, FpuB, FpuOp, FpuStart,
        input  FpuResult, FpuDone,
        output RspValid, RspResult, RspOp, RspTimeout,
        input  RspReady,
        output Busy
    );
endinterface

// File: rtl/fpu_issue_queue.sv
// Command FIFO and single-issue sequencer in front of the FPU: issues one command,
// waits for a rising Done (or times out with a quiet NaN) and returns the response.
module fpu_issue_queue #(
    parameter int PRECISION    = 32,
    parameter int DEPTH        = 4,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input logic             Clk,
    input logic             Reset,
    fpu_issue_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SC_W  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam int WC_W  = $clog2(TIMEOUT);
    localparam int EXP_W = (PRECISION == 64) ? 11 : ((PRECISION == 16) ? 5 : 8);

    localparam logic [CNT_W-1:0]     DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [SC_W-1:0]      START_LAST = SC_W'(START_CYCLES - 1);
    localparam logic [WC_W-1:0]      WAIT_LAST  = WC_W'(TIMEOUT - 1);
    localparam logic [PRECISION-1:0] QNAN       =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(PRECISION - EXP_W - 2){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    logic [PRECISION-1:0] mem_a  [DEPTH];
    logic [PRECISION-1:0] mem_b  [DEPTH];
    logic [1:0]           mem_op [DEPTH];

    state_t               state_reg, state_next;
    logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic [PRECISION-1:0] fpu_a_reg, fpu_a_next;
    logic [PRECISION-1:0] fpu_b_reg, fpu_b_next;
    logic [1:0]           fpu_op_reg, fpu_op_next;
    logic                 fpu_start_reg, fpu_start_next;
    logic [SC_W-1:0]      start_cnt_reg, start_cnt_next;
    logic [WC_W-1:0]      wait_cnt_reg, wait_cnt_next;
    logic                 done_prev_reg, done_prev_next;
    logic [PRECISION-1:0] rsp_result_reg, rsp_result_next;
    logic [1:0]           rsp_op_reg, rsp_op_next;
    logic                 rsp_valid_reg, rsp_valid_next;
    logic                 rsp_timeout_reg, rsp_timeout_next;

    logic cmd_ready;
    logic push;
    logic pop;
    logic done_rise;

    // No full-bypass: readiness depends only on the registered occupancy.
    assign cmd_ready = (count_reg < DEPTH_C);
    assign push      = bus.CmdValid && cmd_ready;
    assign pop       = (state_reg == IDLE) && (count_reg != '0);
    assign done_rise = bus.FpuDone && !done_prev_reg;

    // Storage needs no reset; only pointers and count define occupancy.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_a[wr_ptr_reg]  <= bus.CmdA;
            mem_b[wr_ptr_reg]  <= bus.CmdB;
            mem_op[wr_ptr_reg] <= bus.CmdOp;
        end
    end

    always_comb begin
        state_next       = state_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        count_next       = count_reg;
        fpu_a_next       = fpu_a_reg;
        fpu_b_next       = fpu_b_reg;
        fpu_op_next      = fpu_op_reg;
        fpu_start_next   = fpu_start_reg;
        start_cnt_next   = start_cnt_reg;
        wait_cnt_next    = wait_cnt_reg;
        done_prev_next   = bus.FpuDone;
        rsp_result_next  = rsp_result_reg;
        rsp_op_next      = rsp_op_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_timeout_next = rsp_timeout_reg;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase

        case (state_reg)
            IDLE: begin
                if (pop) begin
                    fpu_a_next     = mem_a[rd_ptr_reg];
                    fpu_b_next     = mem_b[rd_ptr_reg];
                    fpu_op_next    = mem_op[rd_ptr_reg];
                    fpu_start_next = 1'b1;
                    start_cnt_next = '0;
                    state_next     = START;
                end
            end
            START: begin
                if (start_cnt_reg == START_LAST) begin
                    fpu_start_next = 1'b0;
                    wait_cnt_next  = '0;
                    state_next     = WAIT;
                end else begin
                    start_cnt_next = start_cnt_reg + SC_W'(1);
                end
            end
            WAIT: begin
                // A completion edge takes priority over an expiring timeout.
                if (done_rise) begin
                    rsp_result_next  = bus.FpuResult;
                    rsp_op_next      = fpu_op_reg;
                    rsp_timeout_next = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = RESP;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    rsp_result_next  = QNAN;
                    rsp_op_next      = fpu_op_reg;
                    rsp_timeout_next = 1'b1;
                    rsp_valid_next   = 1'b1;
                    state_next       = RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WC_W'(1);
                end
            end
            RESP: begin
                if (bus.RspReady) begin
                    rsp_valid_next   = 1'b0;
                    rsp_timeout_next = 1'b0;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg       <= IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            fpu_a_reg       <= '0;
            fpu_b_reg       <= '0;
            fpu_op_reg      <= '0;
            fpu_start_reg   <= 1'b0;
            start_cnt_reg   <= '0;
            wait_cnt_reg    <= '0;
            done_prev_reg   <= 1'b0;
            rsp_result_reg  <= '0;
            rsp_op_reg      <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            fpu_a_reg       <= fpu_a_next;
            fpu_b_reg       <= fpu_b_next;
            fpu_op_reg      <= fpu_op_next;
            fpu_start_reg   <= fpu_start_next;
            start_cnt_reg   <= start_cnt_next;
            wait_cnt_reg    <= wait_cnt_next;
            done_prev_reg   <= done_prev_next;
            rsp_result_reg  <= rsp_result_next;
            rsp_op_reg      <= rsp_op_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    assign bus.CmdReady   = cmd_ready;
    assign bus.FpuA       = fpu_a_reg;
    assign bus.FpuB       = fpu_b_reg;
    assign bus.FpuOp      = fpu_op_reg;
    assign bus.FpuStart   = fpu_start_reg;
    assign bus.RspValid   = rsp_valid_reg;
    assign bus.RspResult  = rsp_result_reg;
    assign bus.RspOp      = rsp_op_reg;
    assign bus.RspTimeout = rsp_timeout_reg;
    assign bus.Busy       = (state_reg != IDLE) || (count_reg != '0);
endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed bench for fpu_issue_queue: an FPU model answers issued commands and a
// scoreboard queue holds the response expected for every accepted command.
module tb_fpu_issue_queue;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef struct packed {
        logic [31:0] res;
        logic [1:0]  op;
        logic        to;
    } rsp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    fpu_issue_queue_if #(.PRECISION(32)) bus ();

    fpu_issue_queue #(
        .PRECISION(32), .DEPTH(4), .START_CYCLES(2), .TIMEOUT(64)
    ) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus)
    );

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];

    // FPU model: 0 = pulse Done a fixed delay after FpuStart falls, 1 = never, 2 = stuck high
    int   done_mode  = 0;
    int   done_delay = 10;
    int   mcnt       = 0;
    logic start_d    = 1'b0;

    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        if (a == 32'h404CCCCD && b == 32'h3F800000 && op == 2'b00) return 32'h40866666;
        return a + b + {30'd0, op};
    endfunction

    always @(negedge Clk) begin
        bus.FpuDone   = (done_mode == 2);
        bus.FpuResult = $urandom;
        if (start_d && !bus.FpuStart && done_mode == 0) begin
            mcnt = done_delay;
        end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                bus.FpuDone   = 1'b1;
                bus.FpuResult = fpu_model(bus.FpuA, bus.FpuB, bus.FpuOp);
            end
        end
        start_d = bus.FpuStart;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op, input logic to);
        int n = 0;
        rsp_t e;
        bus.CmdValid = 1'b1;
        bus.CmdA     = a;
        bus.CmdB     = b;
        bus.CmdOp    = op;
        while (!bus.CmdReady && n < 200) begin
            tick();
            n++;
        end
        chk("push_ready", 64'(n < 200), 64'd1);
        tick();
        bus.CmdValid = 1'b0;
        e.res = to ? QNAN : fpu_model(a, b, op);
        e.op  = op;
        e.to  = to;
        exp_q.push_back(e);
        $display("push A=%h B=%h Op=%0d", a, b, op);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.RspValid && n < 300) begin
            tick();
            n++;
        end
        chk("rsp_valid_seen", 64'(bus.RspValid), 64'd1);
    endtask

    task automatic wait_rsp();
        int   n;
        rsp_t e;
        wait_valid(n);
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        chk("rsp_result", 64'(bus.RspResult), 64'(e.res));
        chk("rsp_op", 64'(bus.RspOp), 64'(e.op));
        chk("rsp_timeout", 64'(bus.RspTimeout), 64'(e.to));
        $display("rsp Result=%h Op=%0d Timeout=%0b", bus.RspResult, bus.RspOp, bus.RspTimeout);
        bus.RspReady = 1'b1;
        tick();
        bus.RspReady = 1'b0;
        chk("rsp_cleared", 64'(bus.RspValid), 64'd0);
        chk("rsp_to_cleared", 64'(bus.RspTimeout), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   acc;
        int   idx;
        logic seen;
        logic [1:0] fill_ops [6];
        fill_ops = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        bus.CmdValid = 1'b0;
        bus.CmdA     = '0;
        bus.CmdB     = '0;
        bus.CmdOp    = '0;
        bus.RspReady = 1'b0;

        // Asynchronous reset before any clock edge
        #2 Reset = 1'b1;
        #1;
        chk("rst_cmdready", 64'(bus.CmdReady), 64'd1);
        chk("rst_rspvalid", 64'(bus.RspValid), 64'd0);
        chk("rst_fpustart", 64'(bus.FpuStart), 64'd0);
        chk("rst_busy", 64'(bus.Busy), 64'd0);
        chk("rst_fpua", 64'(bus.FpuA), 64'd0);
        chk("rst_rspresult", 64'(bus.RspResult), 64'd0);
        tick();
        tick();
        Reset = 1'b0;
        tick();

        // 1. Single add, FpuStart width
        push_cmd(32'h404CCCCD, 32'h3F800000, 2'b00, 1'b0);
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.FpuStart) n++;
        end
        chk("start_cycles", 64'(n), 64'd2);
        wait_rsp();

        // 2. Fill with no response consumption, then drain in order
        bus.RspReady = 1'b0;
        acc = 0;
        idx = 0;
        bus.CmdValid = 1'b1;
        bus.CmdA = 32'h1000;
        bus.CmdB = 32'd0;
        bus.CmdOp = fill_ops[0];
        for (int c = 0; c < 20; c++) begin
            if (bus.CmdValid && bus.CmdReady) begin
                exp_q.push_back('{res: fpu_model(bus.CmdA, bus.CmdB, bus.CmdOp), op: bus.CmdOp, to: 1'b0});
                $display("push A=%h B=%h Op=%0d", bus.CmdA, bus.CmdB, bus.CmdOp);
                acc++;
                tick();
                idx++;
                if (idx < 6) begin
                    bus.CmdA  = 32'h1000 * (idx + 1);
                    bus.CmdB  = 32'(idx);
                    bus.CmdOp = fill_ops[idx];
                end else begin
                    bus.CmdValid = 1'b0;
                end
            end else begin
                tick();
            end
        end
        chk("fill_accepted", 64'(acc), 64'd5);
        chk("fill_cmdready", 64'(bus.CmdReady), 64'd0);
        chk("fill_busy", 64'(bus.Busy), 64'd1);
        wait_rsp();
        push_cmd(32'h6000, 32'd5, fill_ops[5], 1'b0);
        for (int r = 0; r < 5; r++) wait_rsp();

        // 3. Timeout: Done never rises
        done_mode = 1;
        push_cmd(32'h11111111, 32'h22222222, 2'b11, 1'b1);
        n = 0;
        while (!bus.FpuStart && n < 50) begin tick(); n++; end
        n = 0;
        while (bus.FpuStart && n < 50) begin tick(); n++; end
        n = 0;
        while (!bus.RspValid && n < 200) begin tick(); n++; end
        chk("timeout_latency", 64'(n), 64'd64);
        wait_rsp();
        done_mode = 0;
        push_cmd(32'h00000100, 32'h00000200, 2'b10, 1'b0);
        wait_rsp();

        // 4. Done stuck high is not a completion
        done_mode = 2;
        tick();
        push_cmd(32'h0000AAAA, 32'h00005555, 2'b01, 1'b1);
        wait_rsp();
        done_mode = 0;
        push_cmd(32'h00000ABC, 32'h00000DEF, 2'b00, 1'b0);
        wait_rsp();

        // 5. Response backpressure with a queued command
        push_cmd(32'h12345678, 32'h00000001, 2'b10, 1'b0);
        wait_valid(n);
        push_cmd(32'h0BADBEEF, 32'h00000002, 2'b11, 1'b0);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("bp_valid", 64'(bus.RspValid), 64'd1);
            chk("bp_result", 64'(bus.RspResult), 64'(exp_q[0].res));
            chk("bp_fpustart", 64'(bus.FpuStart), 64'd0);
            chk("bp_count", 64'(dut.count_reg), 64'd1);
        end
        wait_rsp();
        wait_rsp();

        // 6. Reset in WAIT with two commands queued
        push_cmd(32'h00000010, 32'h00000020, 2'b00, 1'b0);
        push_cmd(32'h00000030, 32'h00000040, 2'b01, 1'b0);
        push_cmd(32'h00000050, 32'h00000060, 2'b10, 1'b0);
        for (int c = 0; c < 4; c++) tick();
        chk("pre_rst_fpustart", 64'(bus.FpuStart), 64'd0);
        chk("pre_rst_busy", 64'(bus.Busy), 64'd1);
        Reset = 1'b1;
        #1;
        chk("wrst_busy", 64'(bus.Busy), 64'd0);
        chk("wrst_cmdready", 64'(bus.CmdReady), 64'd1);
        chk("wrst_rspvalid", 64'(bus.RspValid), 64'd0);
        chk("wrst_fpustart", 64'(bus.FpuStart), 64'd0);
        chk("wrst_fpua", 64'(bus.FpuA), 64'd0);
        chk("wrst_fpuop", 64'(bus.FpuOp), 64'd0);
        chk("wrst_rspresult", 64'(bus.RspResult), 64'd0);
        chk("wrst_rsptimeout", 64'(bus.RspTimeout), 64'd0);
        exp_q.delete();
        tick();
        Reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.RspValid || bus.FpuStart) seen = 1'b1;
        end
        chk("post_rst_quiet", 64'(seen), 64'd0);
        push_cmd(32'h00000777, 32'h00000111, 2'b11, 1'b0);
        wait_rsp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
